// File: rtl/cell_proc_pipe.sv
// rtl/cell_proc_pipe.sv - handshaked cell processor with per-channel ALU and exact cell average
module cell_proc_pipe #(
    parameter int CH_W   = 8,
    parameter int CH_N   = 3,
    parameter int CELL_N = 3,
    parameter int SAT    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [3:0]                             in_opcode,
    input  logic [CH_W*CH_N*CELL_N*CELL_N-1:0]     in_cell_a,
    input  logic [CH_W*CH_N*CELL_N*CELL_N-1:0]     in_cell_b,
    input  logic [CH_W-1:0]                        in_imm,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [CH_W*CH_N-1:0]                   out_pixel,
    output logic                                   out_err,
    output logic                                   busy
);

    localparam int PIX_W  = CH_W * CH_N;
    localparam int NPIX   = CELL_N * CELL_N;
    localparam int CELL_W = PIX_W * NPIX;
    localparam int CTR    = (NPIX - 1) / 2;
    localparam int SUM_W  = CH_W + $clog2(NPIX);
    localparam int CNT_W  = $clog2(NPIX + SUM_W + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_MULT = 4'd4;
    localparam logic [3:0] OP_MULTI= 4'd5;
    localparam logic [3:0] OP_DIV2 = 4'd6;
    localparam logic [3:0] OP_INV  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_AVG  = 4'd11;

    localparam logic [CH_W-1:0]  MAXV    = '1;
    localparam logic [SUM_W:0]   DIVISOR = (SUM_W+1)'(NPIX);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [CELL_W-1:0]  cell_a_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SUM_W-1:0]   sum_q [CH_N];
    logic [SUM_W-1:0]   rem_q [CH_N];
    logic [SUM_W-1:0]   quot_d [CH_N];
    logic [SUM_W-1:0]   rem_d [CH_N];
    logic [SUM_W:0]     rem_sh;
    logic [PIX_W-1:0]   out_pixel_q;
    logic               out_err_q;
    logic [PIX_W-1:0]   alu_pix;
    logic               alu_err;
    logic [CH_W-1:0]    alu_a, alu_b, alu_r;
    logic [CH_W:0]      alu_s, alu_dif;
    logic [2*CH_W-1:0]  alu_p;
    logic               accept, last_accum, last_div;

    assign accept     = in_valid & in_ready;
    assign last_accum = (cnt_q == CNT_W'(NPIX - 1));
    assign last_div   = (cnt_q == CNT_W'(SUM_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (in_opcode == OP_AVG) ? ACCUM : DONE;
            ACCUM:   if (last_accum) state_d = DIV;
            DIV:     if (last_div) state_d = DONE;
            DONE: begin
                if (accept)         state_d = (in_opcode == OP_AVG) ? ACCUM : DONE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Odd opcodes among 0..5 are the immediate variants: second operand becomes in_imm.
    always_comb begin
        alu_pix = '0;
        alu_a   = '0;
        alu_b   = '0;
        alu_r   = '0;
        alu_s   = '0;
        alu_dif = '0;
        alu_p   = '0;
        for (int c = 0; c < CH_N; c++) begin
            alu_a   = in_cell_a[CTR*PIX_W + c*CH_W +: CH_W];
            alu_b   = (in_opcode[0] && in_opcode < OP_DIV2) ? in_imm
                                                            : in_cell_b[CTR*PIX_W + c*CH_W +: CH_W];
            alu_s   = {1'b0, alu_a} + {1'b0, alu_b};
            alu_dif = {1'b0, alu_a} - {1'b0, alu_b};
            alu_p   = {{CH_W{1'b0}}, alu_a} * {{CH_W{1'b0}}, alu_b};
            case (in_opcode)
                OP_ADD, OP_ADDI:   alu_r = (SAT != 0 && alu_s[CH_W]) ? MAXV : alu_s[CH_W-1:0];
                OP_SUB, OP_SUBI:   alu_r = (SAT != 0 && alu_dif[CH_W]) ? '0 : alu_dif[CH_W-1:0];
                OP_MULT, OP_MULTI: alu_r = (SAT != 0 && |alu_p[2*CH_W-1:CH_W]) ? MAXV
                                                                                : alu_p[CH_W-1:0];
                OP_DIV2:           alu_r = alu_a >> 1;
                OP_INV:            alu_r = ~alu_a;
                OP_AND:            alu_r = alu_a & alu_b;
                OP_OR:             alu_r = alu_a | alu_b;
                OP_NOR:            alu_r = ~(alu_a | alu_b);
                default:           alu_r = '0;
            endcase
            alu_pix[c*CH_W +: CH_W] = alu_r;
        end
        alu_err = (in_opcode > OP_AVG);
    end

    // Restoring division step: the dividend shifts out of sum_q while quotient bits shift in.
    always_comb begin
        rem_sh = '0;
        for (int c = 0; c < CH_N; c++) begin
            rem_sh = {rem_q[c], sum_q[c][SUM_W-1]};
            if (rem_sh >= DIVISOR) begin
                rem_d[c]  = SUM_W'(rem_sh - DIVISOR);
                quot_d[c] = (sum_q[c] << 1) | SUM_W'(1);
            end else begin
                rem_d[c]  = rem_sh[SUM_W-1:0];
                quot_d[c] = sum_q[c] << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cell_a_q    <= '0;
            cnt_q       <= '0;
            out_pixel_q <= '0;
            out_err_q   <= 1'b0;
            for (int c = 0; c < CH_N; c++) begin
                sum_q[c] <= '0;
                rem_q[c] <= '0;
            end
        end else if (accept) begin
            cell_a_q <= in_cell_a;
            cnt_q    <= '0;
            for (int c = 0; c < CH_N; c++) begin
                sum_q[c] <= '0;
                rem_q[c] <= '0;
            end
            if (in_opcode != OP_AVG) begin
                out_pixel_q <= alu_pix;
                out_err_q   <= alu_err;
            end
        end else if (state_q == ACCUM) begin
            cell_a_q <= cell_a_q >> PIX_W;
            cnt_q    <= last_accum ? '0 : cnt_q + 1'b1;
            for (int c = 0; c < CH_N; c++)
                sum_q[c] <= sum_q[c] + SUM_W'(cell_a_q[c*CH_W +: CH_W]);
        end else if (state_q == DIV) begin
            cnt_q <= cnt_q + 1'b1;
            for (int c = 0; c < CH_N; c++) begin
                sum_q[c] <= quot_d[c];
                rem_q[c] <= rem_d[c];
            end
            if (last_div) begin
                for (int c = 0; c < CH_N; c++)
                    out_pixel_q[c*CH_W +: CH_W] <= quot_d[c][CH_W-1:0];
                out_err_q <= 1'b0;
            end
        end
    end

    assign out_pixel = out_pixel_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/cell_proc_pipe.md
# cell_proc_pipe

Parametrised, handshaked cell processor: the next-generation replacement for the combinational cell functions in the cell-processing package. It accepts one instruction per transfer: opcode, cell A, cell B and an immediate. It returns one result pixel computed on the centre pixel of the cells. AVG is the exception and is computed over every pixel of cell A. It sits between the line-buffer/cell-assembly stage and the output-pixel buffer of the image processor, with generic channel width, channel count, cell size and saturation mode.

## Interface
- CH_W, 8, bits per colour channel
- CH_N, 3, channels per pixel; channel 0 = least-significant CH_W bits
- CELL_N, 3, cell edge length; must be odd and ≥1
- SAT, 1, 1 = saturate to [0, 2^CH_W−1]; 0 = wrap modulo 2^CH_W
- Derived: PIX_W = CH_W·CH_N; CELL_W = PIX_W·CELL_N²; CTR = (CELL_N²−1)/2; SUM_W = CH_W + clog2(CELL_N²)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid & in_ready
- in_opcode  in  4  ADD=0 ADDI=1 SUB=2 SUBI=3 MULT=4 MULTI=5 DIV2=6 INV=7 AND=8 OR=9 NOR=10 AVG=11; 12–15 illegal
- in_cell_a  in  CELL_W  pixel p at bits [p·PIX_W +: PIX_W]
- in_cell_b  in  CELL_W  same layout; only pixel CTR used
- in_imm  in  CH_W  immediate, applied to every channel
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts
- out_pixel  out  PIX_W  result pixel
- out_err  out  1  result came from an illegal opcode
- busy  out  1  high in any state other than IDLE

## Operation
- All inputs are captured on acceptance; they may change afterwards.
- FSM states: IDLE, ACCUM, DIV, DONE.
- Per-channel operations, with a = A[CTR] channel, b = B[CTR] channel, i = in_imm:
  - ADD: a+b. ADDI: a+i. SUB: a−b. SUBI: a−i.
  - MULT: a·b. MULTI: a·i.
  - DIV2: a>>1. INV: (2^CH_W−1)−a.
  - AND, OR, NOR: bitwise on a and b.
- Overflow and underflow for ADD, SUB and MULT: SAT=1 clamps to max or 0; SAT=0 keeps the low CH_W bits.
- AVG: per channel, floor(Σ over all CELL_N² pixels of A) / CELL_N². The result is exact, not shift-approximated.
  - Accumulation is SUM_W bits wide, one pixel per cycle in ACCUM.
  - Division is a restoring divider, one quotient bit per cycle in DIV (SUM_W cycles), all channels in parallel.
- Illegal opcode: out_pixel = 0, out_err = 1. No other effect.
- Transitions:
  - IDLE, on accept: non-AVG → DONE with the result registered; AVG → ACCUM.
  - ACCUM → DIV after CELL_N² cycles.
  - DIV → DONE after SUM_W cycles.
  - DONE with out_ready: accepting a new instruction in the same cycle follows the IDLE rules; otherwise → IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- out_valid = (state==DONE).
- out_pixel and out_err are stable while out_valid & !out_ready.

## Timing
- Reset (rst_n sampled low at a clk edge): state=IDLE, out_valid=0, out_pixel=0, out_err=0, busy=0, accumulators cleared. in_ready=1 from the first cycle after the reset edge.
- Reset mid-operation, in any state: the in-flight instruction is discarded and no result is emitted.
- Non-AVG latency: accepted at edge T, out_valid high after edge T+1.
- Non-AVG throughput: one per cycle with out_ready held high.
- AVG latency: 1 + CELL_N² + SUM_W cycles. For the defaults this is 1+9+12 = 22 cycles.
- in_ready is low during ACCUM and DIV.
- No combinational path from in_valid to in_ready or out_valid. out_ready → in_ready is combinational, by design.

## Test plan
- ADD, defaults: A[CTR]={200,100,10}, B[CTR]={100,100,10} → out_pixel {255,200,20} one cycle after accept, out_err=0. Same stimulus with SAT=0 → {44,200,20}.
- SUBI imm=50 on A[CTR]={40,60,255} → {0,10,205}. MULTI imm=2 on {130,3,0} → {255,6,0}.
- AVG: A pixel p has channel c = 10p+c for p=0..8 → out_pixel {40,41,42} exactly 22 cycles after accept. in_ready=0 and busy=1 throughout.
- Backpressure: back-to-back ADDs with out_ready low for 5 cycles → out_pixel held stable and in_ready=0. Release out_ready → the next instruction is accepted in the same cycle and results stream at one per cycle.
- Illegal opcode 13 → out_pixel=0, out_err=1. The following INV on {0,255,15} → {255,0,240} with out_err=0.
- Reset: rst_n low for one edge during cycle 5 of ACCUM → out_valid=0, busy=0, in_ready=1 next cycle, no AVG result ever appears. A subsequent ADD completes normally.
